// File: rtl/uart_rx_oversample.sv
// UART receive front end: 2-flop synchroniser, 16x oversampled majority-vote
// sampling and LSB-first deserialisation with optional parity and one stop bit.
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID       = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] SAMPLE_A  = MID - 4'd2;
    localparam logic [3:0] SAMPLE_B  = MID - 4'd1;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rxs;
    logic [3:0]           tcnt;
    logic [3:0]           tcnt_inc;
    logic [2:0]           bcnt;
    logic                 armed;
    logic                 s_a;
    logic                 s_b;
    logic                 maj;
    logic                 at_mid;
    logic                 bit_end;
    logic                 last_bit;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign maj      = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
    assign at_mid   = (tcnt == MID);
    assign bit_end  = (tcnt == TICK_LAST);
    assign last_bit = (bcnt == LAST_BIT);
    assign tcnt_inc = bit_end ? 4'd0 : tcnt + 4'd1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The stop bit hands back to IDLE at its centre so the next start edge is caught at once.
    always_comb begin
        state_next = state;
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (at_mid && maj) begin
                        state_next = IDLE;
                    end else if (bit_end) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bit_end && last_bit) begin
                        state_next = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (at_mid) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt       <= 4'd0;
            bcnt       <= 3'd0;
            armed      <= 1'b0;
            s_a        <= 1'b0;
            s_b        <= 1'b0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_err_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (baud_tick) begin
                if (tcnt == SAMPLE_A) begin
                    s_a <= rxs;
                end
                if (tcnt == SAMPLE_B) begin
                    s_b <= rxs;
                end
                case (state)
                    IDLE: begin
                        // The detection tick is sample 0 of the start bit, so counting resumes at 1.
                        if (armed && !rxs) begin
                            tcnt      <= 4'd1;
                            bcnt      <= 3'd0;
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                        end else begin
                            tcnt <= 4'd0;
                            if (rxs) begin
                                armed <= 1'b1;
                            end
                        end
                    end
                    START: begin
                        if (at_mid && maj) begin
                            tcnt <= 4'd0;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end
                    DATA: begin
                        tcnt <= tcnt_inc;
                        if (at_mid) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (bit_end) begin
                            bcnt <= last_bit ? 3'd0 : bcnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        tcnt <= tcnt_inc;
                        if (at_mid) begin
                            par_err_q <= ((^shreg) ^ maj) != par_odd_q;
                        end
                    end
                    STOP: begin
                        if (at_mid) begin
                            tcnt       <= 4'd0;
                            rx_valid   <= 1'b1;
                            rx_data    <= shreg;
                            frame_err  <= ~maj;
                            parity_err <= par_en_q & par_err_q;
                            armed      <= maj;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end
                    default: tcnt <= 4'd0;
                endcase
            end
        end
    end

endmodule
